// File: rtl/vga_window_driver_if.sv
// Bus bundle for vga_window_driver: frame-buffer read port, swap handshake,
// scale select and the VGA DAC output group.
//   master : the driver (consumes scale2x/din/wr_end, produces VGA + read side)
//   slave  : the surrounding system (RAM, writer, DAC)
interface vga_window_driver_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned ADDR_W = 17
);
  logic              scale2x;
  logic [PIX_W-1:0]  din;
  logic              wr_end;
  logic              vga_clk;
  logic              vga_hs;
  logic              vga_vs;
  logic              vga_de;
  logic [DATA_W-1:0] vga_rgb;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_end;
  logic              buf_sel;

  modport master (
    input  scale2x, din, wr_end,
    output vga_clk, vga_hs, vga_vs, vga_de, vga_rgb,
    output rd_en, rd_addr, rd_end, buf_sel
  );

  modport slave (
    output scale2x, din, wr_end,
    input  vga_clk, vga_hs, vga_vs, vga_de, vga_rgb,
    input  rd_en, rd_addr, rd_end, buf_sel
  );
endinterface

// File: rtl/vga_window_driver.sv
// VGA timing generator with a centred, optionally pixel-doubled window read
// from an external double-buffered RAM of fixed read latency.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_window_driver_if.master
//           in  scale2x (latched at frame end), din (RAM data), wr_end (writer done)
//           out vga_clk (~clk), vga_hs/vga_vs (active low), vga_de, vga_rgb,
//               rd_en/rd_addr (RAM read), rd_end (frame done), buf_sel (RAM buffer)
module vga_window_driver #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned RD_LAT = 3,
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned H_SPW  = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned V_SPW  = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned WIN_W  = 320,
  parameter int unsigned WIN_H  = 200,
  parameter logic [DATA_W-1:0] BORDER_RGB = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_window_driver_if.master  bus
);

  localparam int unsigned HTOT  = H_SPW + H_BP + H_ACT + H_FP;
  localparam int unsigned VTOT  = V_SPW + V_BP + V_ACT + V_FP;
  localparam int unsigned HA0   = H_SPW + H_BP;
  localparam int unsigned VA0   = V_SPW + V_BP;
  localparam int unsigned HS0_1 = HA0 + (H_ACT - WIN_W) / 2;
  localparam int unsigned HS0_2 = HA0 + (H_ACT - 2 * WIN_W) / 2;
  localparam int unsigned VS0_1 = VA0 + (V_ACT - WIN_H) / 2;
  localparam int unsigned VS0_2 = VA0 + (V_ACT - 2 * WIN_H) / 2;
  localparam int unsigned HC_W  = $clog2(HTOT);
  localparam int unsigned VC_W  = $clog2(VTOT);

  logic [HC_W-1:0]   hcnt, hcnt_nx;
  logic [VC_W-1:0]   vcnt, vcnt_nx;
  logic              scale_q, scale_nx;
  logic              pend_q;
  logic              frame_end_c;

  logic [31:0]       h32, v32, hn32, vn32;
  logic [31:0]       px_h0, px_v0, px_w, px_h;
  logic [31:0]       rd_h0, rd_v0, rd_w, rd_h;
  logic              active_c, in_win_c, rd_on_c;
  logic [ADDR_W-1:0] col_c, row_c, rd_addr_c;
  logic [DATA_W-1:0] pix_c;

  logic              hs_q, vs_q, de_q, rd_en_q, rd_end_q, buf_q;
  logic [DATA_W-1:0] rgb_q;
  logic [ADDR_W-1:0] rd_addr_q;

  // Free-running raster counters and the scale that will apply next cycle.
  always_comb begin
    h32         = 32'(hcnt);
    v32         = 32'(vcnt);
    frame_end_c = (h32 == HTOT - 1) && (v32 == VTOT - 1);
    hcnt_nx     = (h32 == HTOT - 1) ? '0 : hcnt + 1'b1;
    vcnt_nx     = vcnt;
    if (h32 == HTOT - 1) begin
      vcnt_nx = (v32 == VTOT - 1) ? '0 : vcnt + 1'b1;
    end
    scale_nx    = frame_end_c ? bus.scale2x : scale_q;
  end

  // Pixel side: classify the current raster position with the frame's scale.
  always_comb begin
    px_h0    = scale_q ? HS0_2 : HS0_1;
    px_v0    = scale_q ? VS0_2 : VS0_1;
    px_w     = scale_q ? 2 * WIN_W : WIN_W;
    px_h     = scale_q ? 2 * WIN_H : WIN_H;
    active_c = (h32 >= HA0) && (h32 < HA0 + H_ACT) &&
               (v32 >= VA0) && (v32 < VA0 + V_ACT);
    in_win_c = (h32 >= px_h0) && (h32 < px_h0 + px_w) &&
               (v32 >= px_v0) && (v32 < px_v0 + px_h);
  end

  // Read side: looks at the next raster position so the registered strobe is
  // high in the cycle the counter holds that position, RD_LAT ahead of display.
  always_comb begin
    hn32    = 32'(hcnt_nx);
    vn32    = 32'(vcnt_nx);
    rd_h0   = (scale_nx ? HS0_2 : HS0_1) - RD_LAT + 1;
    rd_v0   = scale_nx ? VS0_2 : VS0_1;
    rd_w    = scale_nx ? 2 * WIN_W : WIN_W;
    rd_h    = scale_nx ? 2 * WIN_H : WIN_H;
    rd_on_c = (hn32 >= rd_h0) && (hn32 < rd_h0 + rd_w) &&
              (vn32 >= rd_v0) && (vn32 < rd_v0 + rd_h);
    col_c   = ADDR_W'(hn32 - rd_h0);
    row_c   = ADDR_W'(vn32 - rd_v0);
    if (scale_nx) begin
      col_c = col_c >> 1;
      row_c = row_c >> 1;
    end
    rd_addr_c = rd_on_c ? (row_c * ADDR_W'(WIN_W) + col_c) : '0;
  end

  // Single-bit sources are replicated across the colour word.
  if (PIX_W == 1) begin : g_rep
    assign pix_c = {DATA_W{bus.din[0]}};
  end else begin : g_pass
    assign pix_c = DATA_W'(bus.din);
  end

  // Counters, latched scale, swap handshake and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      scale_q   <= 1'b0;
      pend_q    <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      rgb_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_end_q  <= 1'b0;
      buf_q     <= 1'b0;
    end else begin
      hcnt      <= hcnt_nx;
      vcnt      <= vcnt_nx;
      scale_q   <= scale_nx;
      hs_q      <= !(h32 < H_SPW);
      vs_q      <= !(v32 < V_SPW);
      de_q      <= active_c;
      rgb_q     <= !active_c ? '0 : (in_win_c ? pix_c : BORDER_RGB);
      rd_en_q   <= rd_on_c;
      rd_addr_q <= rd_addr_c;
      rd_end_q  <= frame_end_c;
      // A wr_end on the frame-end cycle itself counts for this swap.
      if (frame_end_c) begin
        if (pend_q || bus.wr_end) begin
          buf_q <= ~buf_q;
        end
        pend_q <= 1'b0;
      end else if (bus.wr_end) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign bus.vga_clk = ~clk;
  assign bus.vga_hs  = hs_q;
  assign bus.vga_vs  = vs_q;
  assign bus.vga_de  = de_q;
  assign bus.vga_rgb = rgb_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_end  = rd_end_q;
  assign bus.buf_sel = buf_q;

endmodule

// File: tb/tb_vga_window_driver.sv
// Self-checking bench for vga_window_driver on a reduced raster, with a
// latency-accurate RAM model and a frame-level reference model.
module tb_vga_window_driver;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PIX_W  = 1;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RD_LAT = 4;
  localparam int unsigned H_ACT  = 40;
  localparam int unsigned H_SPW  = 6;
  localparam int unsigned H_BP   = 4;
  localparam int unsigned H_FP   = 3;
  localparam int unsigned V_ACT  = 24;
  localparam int unsigned V_SPW  = 2;
  localparam int unsigned V_BP   = 3;
  localparam int unsigned V_FP   = 2;
  localparam int unsigned WIN_W  = 16;
  localparam int unsigned WIN_H  = 10;
  localparam int HTOT = H_SPW + H_BP + H_ACT + H_FP;
  localparam int VTOT = V_SPW + V_BP + V_ACT + V_FP;
  localparam int FTOT = HTOT * VTOT;
  localparam int NPIX = WIN_W * WIN_H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_window_driver_if #(.DATA_W(DATA_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  vga_window_driver #(
    .DATA_W(DATA_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
    .H_ACT(H_ACT), .H_SPW(H_SPW), .H_BP(H_BP), .H_FP(H_FP),
    .V_ACT(V_ACT), .V_SPW(V_SPW), .V_BP(V_BP), .V_FP(V_FP),
    .WIN_W(WIN_W), .WIN_H(WIN_H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  bit mem [2][NPIX];
  int n_checks = 0;
  int n_errs   = 0;
  int t;
  int phase;
  int wr_h;
  bit sc_hold;
  bit m_scale, m_buf, m_pend, p_scale, p_buf;
  bit hq_en [8];
  int hq_addr [8];
  bit hq_buf [8];
  int de_cnt, hs_cnt, vs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic int hs0(input bit s);
    return H_SPW + H_BP + (H_ACT - WIN_W * (s ? 2 : 1)) / 2;
  endfunction

  function automatic int vs0(input bit s);
    return V_SPW + V_BP + (V_ACT - WIN_H * (s ? 2 : 1)) / 2;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_hs"},   32'(bus.vga_hs),  32'(1));
    chk({tag, "_vs"},   32'(bus.vga_vs),  32'(1));
    chk({tag, "_de"},   32'(bus.vga_de),  32'(0));
    chk({tag, "_rgb"},  32'(bus.vga_rgb), 32'(0));
    chk({tag, "_rden"}, 32'(bus.rd_en),   32'(0));
    chk({tag, "_addr"}, 32'(bus.rd_addr), 32'(0));
    chk({tag, "_end"},  32'(bus.rd_end),  32'(0));
    chk({tag, "_buf"},  32'(bus.buf_sel), 32'(0));
  endtask

  // Expected outputs at cycle t: registered ones reflect raster position t-1,
  // the read strobe reflects position t.
  task automatic chk_cycle();
    int hp, vp, h, v, sz, c, r, st;
    bit act, win, en;
    logic [31:0] rgb, addr;
    hp  = (t - 1) % HTOT;
    vp  = ((t - 1) / HTOT) % VTOT;
    h   = t % HTOT;
    v   = (t / HTOT) % VTOT;
    chk("vga_clk", 32'(bus.vga_clk), 32'(0));
    chk("hs", 32'(bus.vga_hs), 32'((hp < H_SPW) ? 0 : 1));
    chk("vs", 32'(bus.vga_vs), 32'((vp < V_SPW) ? 0 : 1));
    act = (hp >= H_SPW + H_BP) && (hp < H_SPW + H_BP + H_ACT) &&
          (vp >= V_SPW + V_BP) && (vp < V_SPW + V_BP + V_ACT);
    chk("de", 32'(bus.vga_de), 32'(act));
    sz  = p_scale ? 2 : 1;
    win = (hp >= hs0(p_scale)) && (hp < hs0(p_scale) + WIN_W * sz) &&
          (vp >= vs0(p_scale)) && (vp < vs0(p_scale) + WIN_H * sz);
    if (!act) rgb = 0;
    else if (!win) rgb = 32'hFFFF;
    else begin
      c   = (hp - hs0(p_scale)) / sz;
      r   = (vp - vs0(p_scale)) / sz;
      rgb = mem[p_buf][r * WIN_W + c] ? 32'hFFFF : 32'h0;
    end
    chk("rgb", 32'(bus.vga_rgb), rgb);
    sz  = m_scale ? 2 : 1;
    st  = hs0(m_scale) - RD_LAT + 1;
    en  = (h >= st) && (h < st + WIN_W * sz) &&
          (v >= vs0(m_scale)) && (v < vs0(m_scale) + WIN_H * sz);
    addr = en ? 32'(((v - vs0(m_scale)) / sz) * WIN_W + (h - st) / sz) : 32'h0;
    chk("rd_en", 32'(bus.rd_en), 32'(en));
    chk("rd_addr", 32'(bus.rd_addr), addr);
    chk("rd_end", 32'(bus.rd_end), 32'((hp == HTOT - 1 && vp == VTOT - 1) ? 1 : 0));
    chk("buf_sel", 32'(bus.buf_sel), 32'(m_buf));
    de_cnt += bus.vga_de ? 1 : 0;
    hs_cnt += bus.vga_hs ? 0 : 1;
    vs_cnt += bus.vga_vs ? 0 : 1;
    if (t % FTOT == 0) begin
      chk("frame_de", 32'(de_cnt), 32'(H_ACT * V_ACT));
      chk("frame_hs", 32'(hs_cnt), 32'(H_SPW * VTOT));
      chk("frame_vs", 32'(vs_cnt), 32'(V_SPW * HTOT));
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end
  endtask

  task automatic init_model();
    t = 0;
    m_scale = 0; m_buf = 0; m_pend = 0; p_scale = 0; p_buf = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      hq_en[i] = 0; hq_addr[i] = 0; hq_buf[i] = 0;
    end
    bus.scale2x = 1'b0;
    bus.wr_end  = 1'b0;
    bus.din     = 1'b0;
  endtask

  task automatic cycle();
    bit sc, we, rd;
    int f, h, v, a;
    @(posedge clk);
    #1;
    t++;
    chk_cycle();
    f = t / FTOT; h = t % HTOT; v = (t / HTOT) % VTOT;
    sc = 0; we = 0;
    if (phase == 0) begin
      if (f == 1) sc = (v >= 10 && v < 13);
      else if (f >= 2) sc = (f > 2) || (v >= 15);
      if (f == 3 && (v == 3 || v == 8) && h == wr_h) we = 1;
    end else begin
      if (f == 0) begin
        sc = (v >= 20);
        we = (h == HTOT - 1) && (v == VTOT - 1);
      end else begin
        if ($urandom_range(0, 499) == 0) sc_hold = ~sc_hold;
        sc = sc_hold;
        we = ($urandom_range(0, 299) == 0);
      end
    end
    bus.scale2x = sc;
    bus.wr_end  = we;
    // RAM: data for a read issued RD_LAT-1 cycles ago is presented now.
    for (int i = 7; i > 0; i--) begin
      hq_en[i] = hq_en[i-1]; hq_addr[i] = hq_addr[i-1]; hq_buf[i] = hq_buf[i-1];
    end
    hq_en[0] = bus.rd_en; hq_addr[0] = int'(bus.rd_addr); hq_buf[0] = bus.buf_sel;
    a = hq_addr[RD_LAT-1];
    if (hq_en[RD_LAT-1] && a < NPIX) rd = mem[hq_buf[RD_LAT-1]][a];
    else rd = 1'($urandom);
    bus.din = rd;
    p_scale = m_scale;
    p_buf   = m_buf;
    if (h == HTOT - 1 && v == VTOT - 1) begin
      m_buf   = m_buf ^ (m_pend | we);
      m_pend  = 0;
      m_scale = sc;
    end else if (we) begin
      m_pend = 1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset({tag, "_async"});
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset({tag, "_hold"});
    end
    init_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++)
        mem[b][i] = 1'($urandom);
    wr_h  = int'($urandom_range(0, HTOT - 1));
    phase = 0;
    init_model();
    do_reset("por");
    // 1x frames, scale glitch, scale change, double wr_end, idle frame.
    while (t < 5 * FTOT + 15 * HTOT + 20) cycle();
    do_reset("mid");
    phase   = 1;
    sc_hold = 1;
    // Frame-end wr_end, then randomized swaps and scale changes.
    while (t < 4 * FTOT + 5) cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/vga_window_driver.md
Name: vga_window_driver

Overview:
Parametrised VGA timing generator and windowed frame-buffer reader. It is the successor to the fixed 320x200 single-bit display driver. It generates hsync, vsync and data-enable, and fetches pixels from an external double-buffered RAM with a configurable read latency. It displays them in a centred window at 1x or 2x (pixel-doubled) scale, with a parametrised border colour outside the window. It sits between the edge-detection frame store and the VGA DAC.

Parameters:
DATA_W, 16, vga_rgb width
PIX_W, 1, din width; must be 1 (replicated to DATA_W) or DATA_W (passed through)
ADDR_W, 17, rd_addr width; must satisfy 2^ADDR_W >= WIN_W*WIN_H
RD_LAT, 3, cycles from rd_en/rd_addr to pixel on vga_rgb; allowed range 2..8
H_ACT / H_SPW / H_BP / H_FP, 640 / 96 / 48 / 16, horizontal timing in clocks
V_ACT / V_SPW / V_BP / V_FP, 480 / 2 / 33 / 10, vertical timing in lines
WIN_W / WIN_H, 320 / 200, source image size; 2*WIN_W <= H_ACT and 2*WIN_H <= V_ACT
BORDER_RGB, all ones, colour inside the active area but outside the window

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
scale2x  in  1  0 = 1x window, 1 = 2x window; sampled at frame end only
din  in  PIX_W  pixel data from RAM
wr_end  in  1  one-cycle pulse: writer has finished a frame
vga_clk  out  1  equals ~clk (combinational)
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low
vga_de  out  1  high during the active area
vga_rgb  out  DATA_W  pixel colour
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_end  out  1  one-cycle pulse on the last clock of each frame
buf_sel  out  1  selects which RAM buffer is read

Behaviour:
- Counters: hcnt runs 0..HTOT-1, where HTOT = H_SPW+H_BP+H_ACT+H_FP. vcnt increments when hcnt wraps and runs 0..VTOT-1. Both free-run out of reset.
- All outputs are registered except vga_clk.
  - vga_hs = registered (hcnt < H_SPW).
  - vga_vs = registered (vcnt < V_SPW).
  - vga_de = registered active-area test.
  - All three lag their counters by exactly 1 cycle.
- Window geometry. S = 2 when the latched scale is 1, otherwise S = 1.
  - Window size: WIN_W*S columns by WIN_H*S rows.
  - Horizontal start HS0 = H_SPW+H_BP+(H_ACT-WIN_W*S)/2.
  - Vertical start VS0 = V_SPW+V_BP+(V_ACT-WIN_H*S)/2.
- Read side:
  - rd_en = 1 is registered for hcnt in [HS0-RD_LAT+1, HS0-RD_LAT+WIN_W*S] on window rows; 0 otherwise.
  - On each such cycle, with col = hcnt-(HS0-RD_LAT+1) and row = vcnt-VS0, rd_addr = (row/S)*WIN_W + col/S.
  - At 2x, each address repeats on 2 consecutive cycles and each source row is read on 2 lines.
  - rd_addr = 0 whenever rd_en = 0.
- Pixel side:
  - din is sampled RD_LAT-1 cycles after the matching rd_en/rd_addr cycle.
  - vga_rgb shows that pixel RD_LAT cycles after rd_en, aligned with vga_de. When PIX_W = 1 the value is din replicated DATA_W times.
  - Outside the window but inside the active area, vga_rgb = BORDER_RGB.
  - Outside the active area, vga_rgb = 0.
- Frame end: hcnt = HTOT-1 and vcnt = VTOT-1.
  - rd_end pulses high for the one cycle following frame end.
  - scale2x is latched at frame end; a change mid-frame has no effect until the next frame.
- Swap handshake:
  - wr_end sets a pending flag.
  - At frame end, if pending is set or wr_end is high in that same cycle, buf_sel toggles and pending clears.
  - Multiple wr_end pulses within one frame cause one toggle only.
- Reset values (held for as long as rst_n is low, including mid-frame):
  - hcnt = vcnt = 0; latched scale = 0; pending = 0.
  - vga_hs = vga_vs = 1; vga_de = 0; vga_rgb = 0.
  - rd_en = 0; rd_addr = 0; rd_end = 0; buf_sel = 0.
  - After release, the first frame starts at hcnt = 0, vcnt = 0.

Test Plan:
1. Defaults, 1x scale, two frames:
   - vga_hs low for 96 of every 800 clocks; vga_vs low for 2 of every 525 lines.
   - vga_de high for 640x480 clocks per frame.
2. 1x window (HS0 = 304, VS0 = 175):
   - First rd_en at vcnt = 175, hcnt = 302 with rd_addr = 0.
   - Last rd_en at vcnt = 374, hcnt = 621 with rd_addr = 63999.
   - With RAM model din = addr[0], vga_rgb alternates 0x0000 / 0xFFFF from hcnt = 304 (registered).
   - Active-area pixels outside the window are 0xFFFF; blanking pixels are 0.
3. scale2x = 1 set mid-frame:
   - The current frame is unchanged.
   - Next frame: HS0 = 144, VS0 = 75. Lines 75 and 76 both read addresses 0,0,1,1,...,319,319; line 77 starts at address 320.
4. wr_end pulsed at frame line 100, and again at line 200:
   - buf_sel toggles 0 -> 1 exactly once, at frame end, coincident with rd_end.
   - The next frame with no wr_end shows no toggle.
5. wr_end asserted exactly on the frame-end cycle: buf_sel toggles in that same frame-end update.
6. rst_n dropped asynchronously at vcnt = 200, hcnt = 400:
   - All outputs take their reset values immediately.
   - After release, timing restarts from hcnt = 0, vcnt = 0 with buf_sel = 0.
